// File: rtl/freq_div_pkg.sv
// Shared definitions for the multi-channel frequency divider:
// configuration field encodings and reset values of the per-channel fields.
package freq_div_pkg;

    typedef enum logic [1:0] {
        SEL_DIV   = 2'd0,
        SEL_HIGH  = 2'd1,
        SEL_PHASE = 2'd2,
        SEL_RSVD  = 2'd3
    } cfg_sel_e;

    localparam int DIV_RST   = 2;
    localparam int HIGH_RST  = 1;
    localparam int PHASE_RST = 0;

endpackage

// File: rtl/freq_div_multi_if.sv
// Control/configuration/output bundle of the multi-channel divider.
// The master side drives enables, sync and config writes; the slave (the
// divider) returns pending flags, divided waveforms and period ticks.
interface freq_div_multi_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] enable;
    logic                sync;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [1:0]          cfg_sel;
    logic [WIDTH-1:0]    cfg_data;
    logic [CHANNELS-1:0] cfg_pend;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;

    modport master (
        output enable, sync, cfg_we, cfg_ch, cfg_sel, cfg_data,
        input  cfg_pend, clk_out, tick
    );

    modport slave (
        input  enable, sync, cfg_we, cfg_ch, cfg_sel, cfg_data,
        output cfg_pend, clk_out, tick
    );

endinterface

// File: rtl/freq_div_channel.sv
// One divider channel: double-buffered DIV/HIGH/PHASE, period counter and
// fully registered waveform/tick outputs. Shadow values move to the active
// set only at period boundaries (disable, enable start, sync, wrap).
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             sync_i,
    input  logic             we_i,
    input  cfg_sel_e         sel_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             pend_o,
    output logic             clkOut_o,
    output logic             tick_o
);

    typedef logic [WIDTH-1:0] word_t;

    // A divisor below 2 cannot form a period with both a start and an end.
    function automatic word_t divEff(input word_t d);
        return (d < word_t'(2)) ? word_t'(2) : d;
    endfunction

    // Phase is clamped to the last count of the period.
    function automatic word_t phaseEff(input word_t p, input word_t de);
        return (p >= de) ? (de - word_t'(1)) : p;
    endfunction

    word_t divAct_q,   divAct_d;
    word_t highAct_q,  highAct_d;
    word_t phaseAct_q, phaseAct_d;
    word_t divSh_q,    divSh_d;
    word_t highSh_q,   highSh_d;
    word_t phaseSh_q,  phaseSh_d;
    word_t cnt_q,      cnt_d;
    logic  en_q,       en_d;
    logic  pend_q,     pend_d;
    logic  clkOut_q,   clkOut_d;
    logic  tick_q,     tick_d;

    logic  startEvt;
    logic  wrapEvt;
    logic  copyEvt;
    word_t newDivEff;
    word_t newPhaseEff;

    assign startEvt    = enable_i && !en_q;
    assign wrapEvt     = enable_i && en_q && (cnt_q == divEff(divAct_q) - word_t'(1));
    assign copyEvt     = !enable_i || startEvt || sync_i || wrapEvt;
    assign newDivEff   = divEff(divAct_d);
    assign newPhaseEff = phaseEff(phaseAct_d, newDivEff);

    // Next-state: boundary copy, counter advance, outputs and shadow writes.
    always_comb begin
        divAct_d   = divAct_q;
        highAct_d  = highAct_q;
        phaseAct_d = phaseAct_q;
        divSh_d    = divSh_q;
        highSh_d   = highSh_q;
        phaseSh_d  = phaseSh_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        clkOut_d   = 1'b0;
        tick_d     = 1'b0;
        en_d       = enable_i;

        if (copyEvt) begin
            divAct_d   = divSh_q;
            highAct_d  = highSh_q;
            phaseAct_d = phaseSh_q;
            pend_d     = 1'b0;
        end

        if (!enable_i) begin
            cnt_d = newPhaseEff;
        end else begin
            if (startEvt || sync_i) begin
                cnt_d = newPhaseEff;
            end else if (wrapEvt) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + word_t'(1);
            end
            clkOut_d = (cnt_d < highAct_d);
            tick_d   = (cnt_d == '0);
        end

        if (we_i) begin
            case (sel_i)
                SEL_DIV: begin
                    divSh_d = data_i;
                    pend_d  = 1'b1;
                end
                SEL_HIGH: begin
                    highSh_d = data_i;
                    pend_d   = 1'b1;
                end
                SEL_PHASE: begin
                    phaseSh_d = data_i;
                    pend_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous return to the default configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divAct_q   <= word_t'(DIV_RST);
            highAct_q  <= word_t'(HIGH_RST);
            phaseAct_q <= word_t'(PHASE_RST);
            divSh_q    <= word_t'(DIV_RST);
            highSh_q   <= word_t'(HIGH_RST);
            phaseSh_q  <= word_t'(PHASE_RST);
            cnt_q      <= '0;
            en_q       <= 1'b0;
            pend_q     <= 1'b0;
            clkOut_q   <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            divAct_q   <= divAct_d;
            highAct_q  <= highAct_d;
            phaseAct_q <= phaseAct_d;
            divSh_q    <= divSh_d;
            highSh_q   <= highSh_d;
            phaseSh_q  <= phaseSh_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            clkOut_q   <= clkOut_d;
            tick_q     <= tick_d;
        end
    end

    assign pend_o   = pend_q;
    assign clkOut_o = clkOut_q;
    assign tick_o   = tick_q;

endmodule

// File: rtl/freq_div_multi.sv
// Multi-channel programmable frequency divider top. Decodes the shared
// configuration port into per-channel write strobes and gathers the
// channel outputs back onto the interface.
module freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    freq_div_multi_if.slave   bus
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] pendVec;
    logic [CHANNELS-1:0] clkOutVec;
    logic [CHANNELS-1:0] tickVec;
    logic                selValid;

    // The reserved field code is dropped here so it never touches a flag.
    assign selValid = (bus.cfg_sel != 2'd3);

    for (genvar g = 0; g < CHANNELS; g++) begin : gCh
        logic chWe;

        // Channel numbers beyond CHANNELS-1 match no instance and are ignored.
        assign chWe = bus.cfg_we && selValid && (bus.cfg_ch == CH_W'(g));

        freq_div_channel #(
            .WIDTH (WIDTH)
        ) uChannel (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable_i (bus.enable[g]),
            .sync_i   (bus.sync),
            .we_i     (chWe),
            .sel_i    (cfg_sel_e'(bus.cfg_sel)),
            .data_i   (bus.cfg_data),
            .pend_o   (pendVec[g]),
            .clkOut_o (clkOutVec[g]),
            .tick_o   (tickVec[g])
        );
    end

    assign bus.cfg_pend = pendVec;
    assign bus.clk_out  = clkOutVec;
    assign bus.tick     = tickVec;

endmodule
